// File: rtl/clock_enable_controller_pkg.sv
// Shared types and constants for the clock-enable scheduler.
package clkctl_pkg;

  parameter int CLKCTL_DIV_WIDTH = 16;

  // Smallest meaningful divisor; a programmed 0 behaves like this.
  localparam int DIV_MIN = 1;

  typedef logic [CLKCTL_DIV_WIDTH-1:0] divisor_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } ch0_state_e;

endpackage

// File: rtl/clock_enable_controller_if.sv
// Config, debug handshake and enable-strobe bundle of the scheduler.
interface clock_enable_controller_if
  import clkctl_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int DIV_WIDTH = CLKCTL_DIV_WIDTH
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                 CfgWrite;
  logic [CH_W-1:0]      CfgChannel;
  logic [DIV_WIDTH-1:0] CfgDivisor;
  logic [NUM_CH-1:0]    CfgBusy;
  logic                 HaltReq;
  logic                 StepReq;
  logic                 StepAck;
  logic                 Halted;
  logic [NUM_CH-1:0]    Enable;

  modport master (
    output CfgWrite, CfgChannel, CfgDivisor, HaltReq, StepReq,
    input  CfgBusy, StepAck, Halted, Enable
  );

  modport slave (
    input  CfgWrite, CfgChannel, CfgDivisor, HaltReq, StepReq,
    output CfgBusy, StepAck, Halted, Enable
  );

endinterface

// File: rtl/clock_enable_controller_channel.sv
// One enable channel: down-counter, active/pending divisor, busy flag and
// the registered strobe. Hold freezes the counter without pulsing, Fire
// forces a single pulse, Restart reloads the counter without pulsing.
module clock_enable_channel
  import clkctl_pkg::*;
#(
  parameter int DIV_WIDTH = CLKCTL_DIV_WIDTH,
  parameter int RESET_DIV = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 CfgWrite,
  input  logic [DIV_WIDTH-1:0] CfgDivisor,
  input  logic                 Hold,
  input  logic                 Fire,
  input  logic                 Restart,
  output logic                 Terminal,
  output logic                 CfgBusy,
  output logic                 Enable
);

  localparam logic [DIV_WIDTH-1:0] RESET_ACT = DIV_WIDTH'(RESET_DIV);
  localparam logic [DIV_WIDTH-1:0] RESET_CNT =
    (RESET_DIV > DIV_MIN) ? DIV_WIDTH'(RESET_DIV - DIV_MIN) : '0;

  logic [DIV_WIDTH-1:0] count;
  logic [DIV_WIDTH-1:0] active_div;
  logic [DIV_WIDTH-1:0] pending_div;
  logic [DIV_WIDTH-1:0] next_div;
  logic [DIV_WIDTH-1:0] reload_val;
  logic                 busy;
  logic                 apply;

  assign Terminal   = (count == '0);
  assign apply      = Restart || (!Hold && Terminal);
  assign next_div   = busy ? pending_div : active_div;
  assign reload_val = (next_div == '0) ? '0 : next_div - 1'b1;
  assign CfgBusy    = busy;

  // Count down, pulse and reload at terminal count unless frozen.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count      <= RESET_CNT;
      active_div <= RESET_ACT;
      Enable     <= 1'b0;
    end else begin
      Enable <= Fire;
      if (Restart) begin
        count      <= reload_val;
        active_div <= next_div;
      end else if (!Hold) begin
        if (Terminal) begin
          Enable     <= 1'b1;
          count      <= reload_val;
          active_div <= next_div;
        end else begin
          count <= count - 1'b1;
        end
      end
    end
  end

  // Capture writes; a write on a reload edge stays pending for the next one.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pending_div <= RESET_ACT;
      busy        <= 1'b0;
    end else if (CfgWrite) begin
      pending_div <= CfgDivisor;
      busy        <= 1'b1;
    end else if (apply) begin
      busy <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_enable_controller.sv
// Clock-enable scheduler top: config decode, channel array and the
// channel-0 halt/single-step state machine.
module clock_enable_controller
  import clkctl_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int DIV_WIDTH = CLKCTL_DIV_WIDTH,
  parameter int RESET_DIV = 1
) (
  input  logic                      Clock,
  input  logic                      Reset,
  clock_enable_controller_if.slave  bus
);

  ch0_state_e        state;
  ch0_state_e        state_next;
  logic              hold0;
  logic              fire0;
  logic              restart0;
  logic [NUM_CH-1:0] term;
  logic [NUM_CH-1:0] busy_vec;
  logic [NUM_CH-1:0] en_vec;
  logic              unused_term;

  assign unused_term = ^term;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr;
    assign wr = bus.CfgWrite && (int'(bus.CfgChannel) == i);

    clock_enable_channel #(
      .DIV_WIDTH (DIV_WIDTH),
      .RESET_DIV (RESET_DIV)
    ) u_channel (
      .Clock      (Clock),
      .Reset      (Reset),
      .CfgWrite   (wr),
      .CfgDivisor (bus.CfgDivisor),
      .Hold       ((i == 0) ? hold0 : 1'b0),
      .Fire       ((i == 0) ? fire0 : 1'b0),
      .Restart    ((i == 0) ? restart0 : 1'b0),
      .Terminal   (term[i]),
      .CfgBusy    (busy_vec[i]),
      .Enable     (en_vec[i])
    );
  end

  assign bus.Enable  = en_vec;
  assign bus.CfgBusy = busy_vec;
  assign bus.Halted  = (state != RUN);
  assign bus.StepAck = (state == STEP);

  // Channel-0 debug state register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= RUN;
    else        state <= state_next;
  end

  // Halt at a terminal count, step on request (step wins), resume with reload.
  always_comb begin
    state_next = state;
    hold0      = 1'b0;
    fire0      = 1'b0;
    restart0   = 1'b0;
    case (state)
      RUN: begin
        if (bus.HaltReq && term[0]) begin
          hold0      = 1'b1;
          state_next = HALTED;
        end
      end
      HALTED: begin
        hold0 = 1'b1;
        if (bus.StepReq) begin
          fire0      = 1'b1;
          state_next = STEP;
        end else if (!bus.HaltReq) begin
          hold0      = 1'b0;
          restart0   = 1'b1;
          state_next = RUN;
        end
      end
      STEP: begin
        hold0 = 1'b1;
        if (!bus.StepReq) state_next = HALTED;
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: doc/clock_enable_controller.md
# clock_enable_controller

Synthesizable clock-enable scheduler for the system chip. It divides the single system clock into `NUM_CH` periodic one-cycle enable strobes: channel 0 is the CPU core enable, and the others drive the timer and UART tick. Each strobe has a run-time programmable divisor. Channel 0 also supports halt and single-step for debug. All downstream logic stays on one clock and qualifies on `Enable[i]`; no derived clocks are generated.

## Interface
- `NUM_CH`, 3: number of enable channels (≥1).
- `DIV_WIDTH`, 16: divisor width.
- `RESET_DIV`, 1: divisor loaded into every channel at reset.
- `Clock`  in  1  system clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `CfgWrite`  in  1  one-cycle divisor write strobe.
- `CfgChannel`  in  $clog2(NUM_CH) (min 1)  target channel.
- `CfgDivisor`  in  DIV_WIDTH  new divisor.
- `CfgBusy`  out  NUM_CH  per-channel "pending divisor not yet applied".
- `HaltReq`  in  1  level request to halt channel 0.
- `StepReq`  in  1  single-step request (4-phase handshake).
- `StepAck`  out  1  step acknowledge.
- `Halted`  out  1  channel 0 is halted.
- `Enable`  out  NUM_CH  one-cycle enable strobes, registered.

## Operation
- Divisor D: `Enable[i]` is high exactly 1 cycle in every D. D=0 is treated as D=1, which gives a continuous high level.
- Each channel has a down-counter that is loaded with D−1. At count 0 the channel pulses `Enable` in the next cycle and reloads from the active divisor.
- Config:
  - `CfgWrite` latches `CfgDivisor` into the channel's pending register and sets `CfgBusy[ch]`.
  - The pending value becomes active at that channel's next reload, and `CfgBusy[ch]` clears in the same cycle.
  - The period in progress is never truncated or stretched.
  - A second write while busy overwrites the pending value (last wins).
  - A `CfgChannel` ≥ `NUM_CH` is ignored.
- Channel 0 FSM:
  - **RUN**: normal counting.
    - If `HaltReq`=1 at a terminal count, that pulse is suppressed, the counter holds at 0, and the FSM goes to HALTED.
  - **HALTED**: `Halted`=1, `Enable[0]`=0.
    - `StepReq`=1 goes to STEP: one `Enable[0]` pulse and `StepAck`=1.
    - `HaltReq`=0 with `StepReq`=0 goes to RUN: the counter reloads D−1 and the next pulse follows D cycles later.
  - **STEP**: `StepAck` stays 1 and there are no further pulses.
    - `StepReq`=0 drops `StepAck`; the FSM goes to HALTED.
- `HaltReq`/`StepReq` have no effect on channels ≥1.
- Pending config writes apply on channel 0 at the resume reload.

## Timing
- Reset values:
  - `Enable`=0, `CfgBusy`=0, `Halted`=0, `StepAck`=0, FSM=RUN.
  - All active divisors = `RESET_DIV`; counters = `RESET_DIV`−1.
- The first `Enable[i]` pulse occurs in cycle D after reset release, counting the first active edge as cycle 1. With D=1, `Enable` goes high from cycle 1.
- Config apply latency: from the `CfgWrite` edge to the next terminal count of that channel (0 to D_old−1 cycles).
  - A write in the same cycle as a terminal count applies at the following reload.
- Halt latency: `Halted` rises the cycle after the first channel-0 terminal count that sees `HaltReq`=1. The suppressed pulse is that terminal-count pulse.
- Step: `Enable[0]` and `StepAck` rise together, 1 cycle after `StepReq` is sampled high in HALTED.
  - `StepAck` falls 1 cycle after `StepReq` is sampled low.
- `HaltReq` and `StepReq` both high in HALTED: step takes priority.
- Asynchronous reset mid-step or mid-halt returns immediately to the reset values.

## Structure
- `clkctl_pkg` holds:
  - `divisor_t` (logic [DIV_WIDTH-1:0] through a package parameter default).
  - `ch0_state_e` {RUN, HALTED, STEP}.
  - The constant `DIV_MIN`=1.
- One sub-module, `clock_enable_channel`, contains one counter, the active and pending divisor, the busy flag and the registered strobe. It has a `Hold` input (used by channel 0) and a `Fire` input (one-shot pulse).
- The top level instantiates `NUM_CH` channels and implements the channel-0 FSM and config decode.

## Test plan
- Reset, `RESET_DIV`=1, 10 cycles → all `Enable` bits high from cycle 1; `CfgBusy`=0.
- Write ch1 D=4, then mid-period write ch1 D=3 while `CfgBusy[1]`=1:
  - Period 4 completes intact; after that, pulses every 3 cycles.
  - `CfgBusy[1]` clears at that reload.
- ch0 D=5, assert `HaltReq` 2 cycles after a pulse → no further `Enable[0]`; `Halted`=1 the cycle after the next terminal count; ch1/ch2 are unaffected.
- While halted, 4-phase step three times → exactly three single-cycle `Enable[0]` pulses, each coincident with `StepAck` rise.
- Drop `HaltReq` → next `Enable[0]` 5 cycles later; a config written during halt is applied at resume.
- Assert `Reset` low during STEP with `StepAck`=1 → all outputs 0 asynchronously; after release, the first pulse occurs at cycle `RESET_DIV`.
